// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and widths for the IF/MEM memory port arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam int LAT_CNT_W    = 8;
    localparam int STARVE_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/arb_starve_ctr.sv
// ============================================================================
// arb_starve_ctr : saturating count of fetch losses, flags a forced fetch win
// Revision       : 1.0
// ============================================================================
`default_nettype none

module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic loss_i,
    input  logic win_i,
    output logic force_o
);

    logic [STARVE_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (win_i) begin
            cnt_q <= '0;
        end else if (loss_i && (cnt_q != {STARVE_CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign force_o = (cnt_q == STARVE_CNT_W'(STARVE_LIMIT));

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one fixed-latency memory between fetch and data
// Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN
// Revision         : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
        (MEM_LATENCY < 1) ? '0 : LAT_CNT_W'(MEM_LATENCY - 1);

    // Out-of-range configurations are unsupported; nothing extra is built.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_cfg
    end

    arb_state_e           state_q;
    owner_e               own_q;
    logic                 we_q;
    logic [LAT_CNT_W-1:0] cnt_q;
    logic                 mem_en_q, mem_we_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q, if_rdata_q, dm_rdata_q;
    logic                 if_valid_q, dm_valid_q;
    logic                 force_if, grant_dm;

`ifdef MEM_ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .loss_i  ((state_q == IDLE) && grant_dm && if_req),
        .win_i   ((state_q == IDLE) && if_req && !grant_dm),
        .force_o (force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    assign grant_dm = dm_req && !(force_if && if_req);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= IDLE;
            own_q       <= OWN_IF;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (if_req || dm_req) begin
                        own_q      <= grant_dm ? OWN_DM : OWN_IF;
                        we_q       <= grant_dm && dm_we;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= grant_dm && dm_we;
                        mem_addr_q <= grant_dm ? dm_addr : if_addr;
                        if (grant_dm) begin
                            mem_wdata_q <= dm_wdata;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= LAT_LOAD;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (own_q == OWN_IF) begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end else begin
                            dm_rdata_q <= we_q ? '0 : mem_rdata;
                            dm_valid_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_stall  = if_req && !if_valid_q;
    assign dm_stall  = dm_req && !dm_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed scenarios plus randomized traffic vs a model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int LAT = 1;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, if_stall, dm_valid, dm_stall, mem_en, mem_we;

    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;
    logic [31:0] mem_arr [16];
    logic [31:0] rd_pipe [LAT];
    logic [31:0] ref_mem [16];

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(2)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 Clk = ~Clk;

    // Memory model: reads return data LAT cycles after mem_en, junk otherwise.
    always @(posedge Clk) begin
        if (pl_en) mem_arr[pl_idx] <= pl_data;
        else if (mem_en && mem_we) mem_arr[mem_addr[5:2]] <= mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[5:2]] : 32'hA5A5_A5A5;
        for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        pl_en = 1'b1; pl_idx = idx[3:0]; pl_data = d; ref_mem[idx] = d;
        step();
        pl_en = 1'b0;
    endtask

    // Runs ncyc cycles (cycle 0 = current) recording pulses; optionally drops req on valid.
    task automatic run_window(input int ncyc, input bit drop,
                              output int if_first, output int dm_first,
                              output int if_cnt, output int dm_cnt,
                              output logic [31:0] en_mask, output logic [31:0] iv_mask);
        if_first = -1; dm_first = -1; if_cnt = 0; dm_cnt = 0;
        en_mask = '0; iv_mask = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) step(); else #1;
            if (mem_en) en_mask[c] = 1'b1;
            if (if_valid) begin
                if (if_first < 0) if_first = c;
                if_cnt++; iv_mask[c] = 1'b1;
                if (drop) if_req = 1'b0;
            end
            if (dm_valid) begin
                if (dm_first < 0) dm_first = c;
                dm_cnt++;
                if (drop) dm_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        step(); step();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_valid, dm_valid} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_valid, dm_valid});
        end
        Reset = 1'b1;
        step();
        checks++;
        if ({mem_en, if_valid, dm_valid, if_stall, dm_stall} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=00000", {mem_en, if_valid, dm_valid, if_stall, dm_stall});
        end
    endtask

    task automatic test_single_fetch();
        preload(1, 32'h2008_0005);
        if_addr = 32'h4; if_req = 1'b1; #1;
        checks++;
        if (if_stall !== 1'b1) begin failures++; $display("FAIL sf_stall_c0 got=%b exp=1", if_stall); end
        step();
        checks++;
        if ({mem_en, mem_we, mem_addr, if_stall} !== {1'b1, 1'b0, 32'h4, 1'b1}) begin
            failures++;
            $display("FAIL sf_issue_c1 got en=%b we=%b addr=%h stall=%b exp en=1 we=0 addr=4 stall=1",
                     mem_en, mem_we, mem_addr, if_stall);
        end
        step();
        checks++;
        if ({if_valid, if_stall, mem_en} !== 3'b010) begin
            failures++; $display("FAIL sf_wait_c2 got=%b exp=010", {if_valid, if_stall, mem_en});
        end
        step();
        checks++;
        if ({if_valid, dm_valid, if_stall} !== 3'b100 || if_rdata !== 32'h2008_0005) begin
            failures++;
            $display("FAIL sf_resp_c3 got v=%b dv=%b stall=%b data=%h exp v=1 dv=0 stall=0 data=20080005",
                     if_valid, dm_valid, if_stall, if_rdata);
        end
        if_req = 1'b0;
        step();
        checks++;
        if (if_valid !== 1'b0 || if_rdata !== 32'h2008_0005) begin
            failures++; $display("FAIL sf_hold got v=%b data=%h exp v=0 data=20080005", if_valid, if_rdata);
        end
    endtask

    task automatic test_data_write();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
        step();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL dw_issue got en=%b we=%b addr=%h wdata=%h exp en=1 we=1 addr=10 wdata=deadbeef",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        step();
        checks++;
        if ({mem_en, mem_we} !== 2'b00) begin
            failures++; $display("FAIL dw_we_idle got=%b exp=00", {mem_en, mem_we});
        end
        step();
        checks++;
        if (dm_valid !== 1'b1 || dm_rdata !== 32'h0 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL dw_resp got dv=%b data=%h iv=%b exp dv=1 data=0 iv=0", dm_valid, dm_rdata, if_valid);
        end
        ref_mem[4] = 32'hDEAD_BEEF;
        dm_req = 1'b0; dm_we = 1'b0;
        step();
        checks++;
        if (if_rdata !== 32'h2008_0005) begin
            failures++; $display("FAIL dw_if_hold got=%h exp=20080005", if_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int itf, dmf, ic, dc;
        logic [31:0] em, im;
        if_addr = 32'h10; dm_addr = 32'h4; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        run_window(10, 1'b1, itf, dmf, ic, dc, em, im);
        checks++;
        if (dmf !== 3 || itf !== 7) begin
            failures++; $display("FAIL sim_order got dm@%0d if@%0d exp dm@3 if@7", dmf, itf);
        end
        checks++;
        if (dm_rdata !== 32'h2008_0005 || if_rdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL sim_data got dm=%h if=%h exp dm=20080005 if=deadbeef", dm_rdata, if_rdata);
        end
        checks++;
        if (em !== 32'h22) begin
            failures++; $display("FAIL sim_en_mask got=%h exp=22", em);
        end
    endtask

    task automatic test_starvation();
        int itf, dmf, ic, dc;
        logic [31:0] em, im;
        if_addr = 32'h0; dm_addr = 32'h8; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        run_window(16, 1'b0, itf, dmf, ic, dc, em, im);
        if_req = 1'b0; dm_req = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        checks++;
        if (itf !== 11 || ic !== 1 || dc !== 3) begin
            failures++; $display("FAIL starve_guard got if@%0d ifs=%0d dms=%0d exp if@11 ifs=1 dms=3", itf, ic, dc);
        end
`else
        checks++;
        if (ic !== 0 || dc !== 4 || dmf !== 3) begin
            failures++; $display("FAIL starve_strict got ifs=%0d dms=%0d dm@%0d exp ifs=0 dms=4 dm@3", ic, dc, dmf);
        end
`endif
        step(); step();
    endtask

    task automatic test_reset_midop();
        int itf, dmf, ic, dc, seen;
        logic [31:0] em, im;
        if_addr = 32'h4; if_req = 1'b1;
        step(); step();
        Reset = 1'b0;
        step();
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_valid, dm_valid} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h exp=0",
                     {mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_valid, dm_valid});
        end
        Reset = 1'b1; if_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (if_valid || mem_en) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL rst_mid_quiet got=%0d exp=0", seen); end
        if_req = 1'b1;
        run_window(6, 1'b1, itf, dmf, ic, dc, em, im);
        checks++;
        if (itf !== 3 || ic !== 1 || if_rdata !== 32'h2008_0005 || em !== 32'h2) begin
            failures++;
            $display("FAIL rst_mid_restart got if@%0d n=%0d data=%h en=%h exp if@3 n=1 data=20080005 en=2",
                     itf, ic, if_rdata, em);
        end
    endtask

    task automatic test_held_req();
        int itf, dmf, ic, dc;
        logic [31:0] em, im;
        if_addr = 32'h4; if_req = 1'b1;
        run_window(8, 1'b0, itf, dmf, ic, dc, em, im);
        if_req = 1'b0;
        checks++;
        if (em !== 32'h22 || im !== 32'h88) begin
            failures++; $display("FAIL held_req got en=%h valid=%h exp en=22 valid=88", em, im);
        end
        step(); step();
    endtask

    task automatic test_random();
        bit ip = 0, dp = 0, dw = 0, got_i, got_d;
        int igap = 0, dgap = 0, iwait = 0, dwait = 0, en_total = 0, done = 0;
        int iidx = 0, didx = 0;
        logic [31:0] dd = '0, expv;
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            got_i = 0; got_d = 0;
            if (mem_en) en_total++;
            if (ip) iwait++;
            if (dp) dwait++;
            checks++;
            if (if_stall !== (if_req & ~if_valid) || dm_stall !== (dm_req & ~dm_valid)) begin
                failures++;
                $display("FAIL rnd_stall c=%0d got if=%b dm=%b exp if=%b dm=%b", cyc, if_stall, dm_stall,
                         if_req & ~if_valid, dm_req & ~dm_valid);
            end
            checks++;
            if ((mem_we && !mem_en) || (if_valid && dm_valid)) begin
                failures++; $display("FAIL rnd_excl c=%0d got we=%b en=%b iv=%b dv=%b", cyc, mem_we, mem_en, if_valid, dm_valid);
            end
            if (if_valid) begin
                expv = ref_mem[iidx];
                checks++;
                if (!ip || if_rdata !== expv || iwait > 12) begin
                    failures++; $display("FAIL rnd_if c=%0d got data=%h pend=%b wait=%0d exp data=%h", cyc, if_rdata, ip, iwait, expv);
                end
                ip = 0; if_req = 1'b0; done++; got_i = 1;
                igap = $urandom_range(0, 2);
            end
            if (dm_valid) begin
                expv = dw ? 32'h0 : ref_mem[didx];
                checks++;
                if (!dp || dm_rdata !== expv || dwait > 12) begin
                    failures++; $display("FAIL rnd_dm c=%0d got data=%h pend=%b wait=%0d exp data=%h", cyc, dm_rdata, dp, dwait, expv);
                end
                if (dw) ref_mem[didx] = dd;
                dp = 0; dm_req = 1'b0; done++; got_d = 1;
                dgap = $urandom_range(1, 3);
            end
            if ((ip && iwait > 40) || (dp && dwait > 40)) begin
                checks++; failures++;
                $display("FAIL rnd_timeout c=%0d got iwait=%0d dwait=%0d exp <=40", cyc, iwait, dwait);
                ip = 0; dp = 0; if_req = 1'b0; dm_req = 1'b0;
            end
            if (!ip && !got_i && cyc < 360) begin
                if (igap > 0) igap--;
                else if ($urandom_range(0, 3) != 0) begin
                    iidx = $urandom_range(0, 15);
                    if_addr = 32'(iidx) << 2; if_req = 1'b1; ip = 1; iwait = 0;
                end
            end
            if (!dp && !got_d && cyc < 360) begin
                if (dgap > 0) dgap--;
                else if ($urandom_range(0, 2) != 0) begin
                    didx = $urandom_range(0, 15);
                    dw = 1'($urandom_range(0, 1));
                    dd = $urandom;
                    dm_addr = 32'(didx) << 2; dm_we = dw; dm_wdata = dd;
                    dm_req = 1'b1; dp = 1; dwait = 0;
                end
            end
        end
        checks++;
        if (en_total !== done || ip || dp) begin
            failures++; $display("FAIL rnd_en_count got en=%0d done=%0d pend=%b%b exp en=done pend=00", en_total, done, ip, dp);
        end
    endtask

    initial begin
        Reset = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < 16; i++) preload(i, 32'h1000_0000 + 32'(i) * 32'h0101_0101);
        test_reset();
        test_single_fetch();
        test_data_write();
        test_simultaneous();
        test_starvation();
        test_reset_midop();
        test_held_req();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
